pc_gen: RTL and testbench

- Parametrised program-counter generator for the core fetch stage. Successor to the single-register PC.
- Adds a one-cycle post-reset enable, valid/ready handshake to instruction fetch, prioritised trap/jump redirect, stall, halt/resume FSM, misaligned-target detection and a fetch counter.
- Sits between the control/branch unit, which supplies redirects, and the instruction-memory interface, which consumes the PC.

---
 rtl/pc_gen_pkg.sv | 26 ++
 rtl/pc_gen_if.sv | 46 ++++
 rtl/pc_next_sel.sv | 60 ++++++
 rtl/pc_gen.sv | 94 +++++++++
 tb/tb_pc_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Compressed-instruction support is selected with the PC_GEN_C_EXT_EN macro.
package pc_gen_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam logic [31:0] RST_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

`ifdef PC_GEN_C_EXT_EN
  localparam logic [1:0]  ALIGN_LSB_MASK = 2'b01;
  localparam int unsigned C_STEP         = 2;
`else
  localparam logic [1:0]  ALIGN_LSB_MASK = 2'b11;
`endif

  // A target is misaligned when any bit covered by the alignment mask is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_LSB_MASK);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Request/PC bus between the control unit, pc_gen and the instruction fetch side.
// PC_GEN_C_EXT_EN adds the is_compressed_i step selector.
interface pc_gen_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             pc_ready_i;
  logic             stall_i;
  logic             jump_en_i;
  logic [XLEN-1:0]  jump_addr_i;
  logic             trap_en_i;
  logic [XLEN-1:0]  trap_addr_i;
  logic             halt_i;
  logic             resume_i;
`ifdef PC_GEN_C_EXT_EN
  logic             is_compressed_i;
`endif
  logic             ena_o;
  logic [XLEN-1:0]  curr_pc_o;
  logic             pc_valid_o;
  logic [XLEN-1:0]  next_pc_o;
  logic             misalign_o;
  logic [XLEN-1:0]  misalign_addr_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    input  pc_ready_i, stall_i, jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
           halt_i, resume_i,
`ifdef PC_GEN_C_EXT_EN
    input  is_compressed_i,
`endif
    output ena_o, curr_pc_o, pc_valid_o, next_pc_o, misalign_o, misalign_addr_o,
           fetch_cnt_o
  );

  modport slave (
    output pc_ready_i, stall_i, jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
           halt_i, resume_i,
`ifdef PC_GEN_C_EXT_EN
    output is_compressed_i,
`endif
    input  ena_o, curr_pc_o, pc_valid_o, next_pc_o, misalign_o, misalign_addr_o,
           fetch_cnt_o
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux (trap > jump > hold > increment) with
// jump-target alignment check. PC_GEN_C_EXT_EN enables the 2-byte step.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = CPU_WIDTH,
  parameter int unsigned INC  = 4
) (
  input  state_e          i_state,
  input  logic [XLEN-1:0] i_curr_pc,
  input  logic            i_pc_ready,
  input  logic            i_stall,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_addr,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_addr,
`ifdef PC_GEN_C_EXT_EN
  input  logic            i_is_compressed,
`endif
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_trap_tgt;
  logic            w_jump_bad;

`ifdef PC_GEN_C_EXT_EN
  assign w_step = i_is_compressed ? XLEN'(C_STEP) : XLEN'(INC);
`else
  assign w_step = XLEN'(INC);
`endif

  // Trap vectors are silently aligned; they never raise misalign.
  assign w_trap_tgt = {i_trap_addr[XLEN-1:2], i_trap_addr[1:0] & ~ALIGN_LSB_MASK};
  assign w_jump_bad = is_misaligned(i_jump_addr[1:0]);

  always_comb begin
    o_next_pc  = i_curr_pc;
    o_misalign = 1'b0;
    case (i_state)
      RUN: begin
        if (i_trap_en) begin
          o_next_pc = w_trap_tgt;
        end else if (i_jump_en && !w_jump_bad) begin
          o_next_pc = i_jump_addr;
        end else if (i_jump_en) begin
          o_misalign = 1'b1;
        end else if (!i_stall && i_pc_ready) begin
          o_next_pc = i_curr_pc + w_step;
        end
      end
      HALT: begin
        if (i_trap_en) o_next_pc = w_trap_tgt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: IDLE/RUN/HALT control, PC register, misalign
// capture and accepted-fetch counter. PC_GEN_C_EXT_EN selects compressed support.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN   = CPU_WIDTH,
  parameter logic [XLEN-1:0] RST_PC = XLEN'(RST_PC_DEFAULT),
  parameter int unsigned     INC    = 4,
  parameter int unsigned     CNT_W  = 32
) (
  input logic      clk,
  input logic      rst_n,
  pc_gen_if.master bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_pc_valid_nxt;
  logic             r_ena;
  logic             r_pc_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_next_pc;
  logic             w_misalign;
  logic             r_misalign;
  logic [XLEN-1:0]  r_misalign_addr;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_fetch_acc;

  pc_next_sel #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_next_sel (
    .i_state         (r_state),
    .i_curr_pc       (r_pc),
    .i_pc_ready      (bus.pc_ready_i),
    .i_stall         (bus.stall_i),
    .i_jump_en       (bus.jump_en_i),
    .i_jump_addr     (bus.jump_addr_i),
    .i_trap_en       (bus.trap_en_i),
    .i_trap_addr     (bus.trap_addr_i),
`ifdef PC_GEN_C_EXT_EN
    .i_is_compressed (bus.is_compressed_i),
`endif
    .o_next_pc       (w_next_pc),
    .o_misalign      (w_misalign)
  );

  // Next state; a trap in RUN wins over a simultaneous halt request.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_valid_nxt = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN:  if (!bus.trap_en_i && bus.halt_i) w_state_nxt = HALT;
      HALT: if (bus.trap_en_i || bus.resume_i) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    w_pc_valid_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_fetch_acc = r_pc_valid && bus.pc_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena           <= 1'b0;
      r_pc_valid      <= 1'b0;
      r_pc            <= RST_PC;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
      r_fetch_cnt     <= '0;
    end else begin
      r_ena      <= 1'b1;
      r_pc_valid <= w_pc_valid_nxt;
      r_pc       <= w_next_pc;
      r_misalign <= w_misalign;
      if (w_misalign)  r_misalign_addr <= bus.jump_addr_i;
      if (w_fetch_acc) r_fetch_cnt     <= r_fetch_cnt + CNT_W'(1);
    end
  end

  assign bus.ena_o           = r_ena;
  assign bus.curr_pc_o       = r_pc;
  assign bus.pc_valid_o      = r_pc_valid;
  assign bus.next_pc_o       = w_next_pc;
  assign bus.misalign_o      = r_misalign;
  assign bus.misalign_addr_o = r_misalign_addr;
  assign bus.fetch_cnt_o     = r_fetch_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table plus randomized run
// against a behavioural model of the fetch PC rules (default 4-byte build).
module tb_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_gen #(
    .XLEN   (XLEN),
    .RST_PC (32'h0000_0000),
    .INC    (4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic jen, input logic [31:0] ja,
                       input logic ten, input logic [31:0] ta, input logic hlt, input logic res);
    bus.pc_ready_i  = rdy;
    bus.stall_i     = stl;
    bus.jump_en_i   = jen;
    bus.jump_addr_i = ja;
    bus.trap_en_i   = ten;
    bus.trap_addr_i = ta;
    bus.halt_i      = hlt;
    bus.resume_i    = res;
`ifdef PC_GEN_C_EXT_EN
    bus.is_compressed_i = 1'b0;
`endif
  endtask

  typedef struct {
    logic        rdy, stl, jen;
    logic [31:0] ja;
    logic        ten;
    logic [31:0] ta;
    logic        hlt, res;
    logic [31:0] pc;
    logic        vld, mis;
    logic [31:0] maddr;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic stl, logic jen, logic [31:0] ja, logic ten,
                              logic [31:0] ta, logic hlt, logic res, logic [31:0] pc,
                              logic vld, logic mis, logic [31:0] maddr, logic [31:0] cnt);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.jen = jen; v.ja = ja; v.ten = ten; v.ta = ta;
    v.hlt = hlt; v.res = res; v.pc = pc; v.vld = vld; v.mis = mis; v.maddr = maddr; v.cnt = cnt;
    return v;
  endfunction

  // Behavioural model state
  int          m_mode;
  logic [31:0] m_pc, m_misaddr, m_cnt;
  logic        m_ena, m_valid, m_mis;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_misaddr = 32'h0; m_cnt = 32'h0;
    m_ena = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently on the bus.
  task automatic model_step(output logic [31:0] npc);
    logic [31:0] pc_n;
    int          mode_n;
    pc_n   = m_pc;
    mode_n = m_mode;
    m_mis  = 1'b0;
    if (m_mode == M_IDLE) begin
      mode_n = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (bus.pc_ready_i) m_cnt = m_cnt + 1;
      if (bus.trap_en_i)                                  pc_n = bus.trap_addr_i & ~32'h3;
      else if (bus.jump_en_i && bus.jump_addr_i % 4 == 0) pc_n = bus.jump_addr_i;
      else if (bus.jump_en_i) begin
        m_mis = 1'b1;
        m_misaddr = bus.jump_addr_i;
      end else if (!bus.stall_i && bus.pc_ready_i)        pc_n = m_pc + 32'd4;
      mode_n = (!bus.trap_en_i && bus.halt_i) ? M_HALT : M_RUN;
    end else begin
      if (bus.trap_en_i) begin
        pc_n = bus.trap_addr_i & ~32'h3;
        mode_n = M_RUN;
      end else if (bus.resume_i) begin
        mode_n = M_RUN;
      end
    end
    npc     = pc_n;
    m_pc    = pc_n;
    m_mode  = mode_n;
    m_ena   = 1'b1;
    m_valid = (mode_n == M_RUN);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    64'(bus.curr_pc_o), 64'h0);
    chk({tag, "_ena"},   64'(bus.ena_o), 64'h0);
    chk({tag, "_valid"}, 64'(bus.pc_valid_o), 64'h0);
    chk({tag, "_mis"},   64'(bus.misalign_o), 64'h0);
    chk({tag, "_maddr"}, 64'(bus.misalign_addr_o), 64'h0);
    chk({tag, "_cnt"},   64'(bus.fetch_cnt_o), 64'h0);
  endtask

  vec_t vecs[25];

  initial begin
    logic [31:0] npc;
    logic [31:0] ja;
    // Directed vectors: inputs for one cycle, outputs expected after the edge.
    vecs[0]  = mk(1,0,0,0,0,0,0,0, 32'h0,1,0,32'h0,0);
    vecs[1]  = mk(1,0,0,0,0,0,0,0, 32'h4,1,0,32'h0,1);
    vecs[2]  = mk(1,0,0,0,0,0,0,0, 32'h8,1,0,32'h0,2);
    vecs[3]  = mk(1,0,0,0,0,0,0,0, 32'hC,1,0,32'h0,3);
    vecs[4]  = mk(1,0,0,0,0,0,0,0, 32'h10,1,0,32'h0,4);
    vecs[5]  = mk(0,0,0,0,0,0,0,0, 32'h10,1,0,32'h0,4);
    vecs[6]  = mk(0,0,0,0,0,0,0,0, 32'h10,1,0,32'h0,4);
    vecs[7]  = mk(0,0,0,0,0,0,0,0, 32'h10,1,0,32'h0,4);
    vecs[8]  = mk(1,0,0,0,0,0,0,0, 32'h14,1,0,32'h0,5);
    vecs[9]  = mk(1,1,1,32'h200,1,32'h103,0,0, 32'h100,1,0,32'h0,6);
    vecs[10] = mk(0,0,1,32'h40,0,0,0,0, 32'h40,1,0,32'h0,6);
    vecs[11] = mk(0,0,1,32'h206,0,0,0,0, 32'h40,1,1,32'h206,6);
    vecs[12] = mk(0,0,0,0,0,0,0,0, 32'h40,1,0,32'h206,6);
    vecs[13] = mk(0,0,1,32'h20,0,0,0,0, 32'h20,1,0,32'h206,6);
    vecs[14] = mk(0,0,0,0,0,0,1,0, 32'h20,0,0,32'h206,6);
    vecs[15] = mk(1,0,0,0,0,0,0,0, 32'h20,0,0,32'h206,6);
    vecs[16] = mk(1,0,0,0,0,0,0,0, 32'h20,0,0,32'h206,6);
    vecs[17] = mk(1,0,0,0,0,0,0,0, 32'h20,0,0,32'h206,6);
    vecs[18] = mk(1,0,0,0,0,0,0,0, 32'h20,0,0,32'h206,6);
    vecs[19] = mk(1,0,0,0,0,0,0,1, 32'h20,1,0,32'h206,6);
    vecs[20] = mk(1,0,0,0,0,0,1,0, 32'h24,0,0,32'h206,7);
    vecs[21] = mk(1,0,0,0,1,32'h300,0,0, 32'h300,1,0,32'h206,7);
    vecs[22] = mk(1,0,1,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC,1,0,32'h206,8);
    vecs[23] = mk(1,0,0,0,0,0,0,0, 32'h0,1,0,32'h206,9);
    vecs[24] = mk(1,0,0,0,0,0,0,0, 32'h4,1,0,32'h206,10);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].rdy, vecs[i].stl, vecs[i].jen, vecs[i].ja,
            vecs[i].ten, vecs[i].ta, vecs[i].hlt, vecs[i].res);
      #3;
      chk($sformatf("v%0d_next_pc", i), 64'(bus.next_pc_o), 64'(vecs[i].pc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    64'(bus.curr_pc_o), 64'(vecs[i].pc));
      chk($sformatf("v%0d_valid", i), 64'(bus.pc_valid_o), 64'(vecs[i].vld));
      chk($sformatf("v%0d_ena", i),   64'(bus.ena_o), 64'h1);
      chk($sformatf("v%0d_mis", i),   64'(bus.misalign_o), 64'(vecs[i].mis));
      chk($sformatf("v%0d_maddr", i), 64'(bus.misalign_addr_o), 64'(vecs[i].maddr));
      chk($sformatf("v%0d_cnt", i),   64'(bus.fetch_cnt_o), 64'(vecs[i].cnt));
    end

    // Asynchronous reset in the middle of a clock period.
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Randomized run against the behavioural model.
    for (int c = 0; c < 3000; c++) begin
      ja = $urandom;
      if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, ja,
            $urandom_range(0, 29) == 0, $urandom,
            $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
      #3;
      model_step(npc);
      chk("rnd_next_pc", 64'(bus.next_pc_o), 64'(npc));
      @(posedge clk);
      #1;
      chk("rnd_pc",    64'(bus.curr_pc_o), 64'(m_pc));
      chk("rnd_valid", 64'(bus.pc_valid_o), 64'(m_valid));
      chk("rnd_ena",   64'(bus.ena_o), 64'(m_ena));
      chk("rnd_mis",   64'(bus.misalign_o), 64'(m_mis));
      chk("rnd_maddr", 64'(bus.misalign_addr_o), 64'(m_misaddr));
      chk("rnd_cnt",   64'(bus.fetch_cnt_o), 64'(m_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
